// File: rtl/countdown_ctrl.sv
// Round countdown controller: loads a clamped seconds value, decrements on each
// timer tick, supports pause/resume/cancel, pulses expiry and decodes BCD digits.
module countdown_ctrl #(
  parameter int unsigned MAX_SECONDS = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic [6:0] load_value,
  input  logic       tick,
  output logic       timer_en,
  output logic [6:0] remaining,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       expired
);

  localparam int unsigned REM_W = 7;
  localparam logic [REM_W-1:0] MAX_VAL = REM_W'(MAX_SECONDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [REM_W-1:0]   remaining_q, remaining_d;
  logic [REM_W-1:0]   clamped_c;
  logic               expired_q, expired_d;
  logic               timer_en_q, running_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      expired_q   <= 1'b0;
      timer_en_q  <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      timer_en_q  <= (state_d == RUNNING);
      running_q   <= (state_d == RUNNING);
    end
  end

  // Next-state: cancel > start > pause > tick; a start cycle swallows pause and tick
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    clamped_c   = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    if (cancel) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE, EXPIRED: begin
          if (start) begin
            remaining_d = clamped_c;
            if (clamped_c == '0) begin
              state_d   = EXPIRED;
              expired_d = 1'b1;
            end else begin
              state_d = RUNNING;
            end
          end
        end
        RUNNING: begin
          if (!start) begin
            if (pause) state_d = PAUSED;
            // A tick alongside pause still counts; reaching zero overrides PAUSED
            if (tick && (remaining_q != '0)) begin
              remaining_d = remaining_q - REM_W'(1);
              if (remaining_q == REM_W'(1)) begin
                state_d   = EXPIRED;
                expired_d = 1'b1;
              end
            end
          end
        end
        PAUSED: begin
          if (!start && pause) state_d = RUNNING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign remaining = remaining_q;
  assign expired   = expired_q;
  assign timer_en  = timer_en_q;
  assign running   = running_q;
  assign bcd_tens  = 4'(remaining_q / REM_W'(10));
  assign bcd_ones  = 4'(remaining_q % REM_W'(10));

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus random requests
// compared each cycle against a behavioural countdown model.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pause, cancel, tick;
  logic [6:0] load_value;
  logic       timer_en, running, expired;
  logic [6:0] remaining;
  logic [3:0] bcd_tens, bcd_ones;

  int checks = 0;
  int failures = 0;

  // Model: 0=idle 1=running 2=paused 3=expired
  int m_state;
  int m_rem;
  int m_exp;

  countdown_ctrl #(.MAX_SECONDS(99)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .cancel     (cancel),
    .load_value (load_value),
    .tick       (tick),
    .timer_en   (timer_en),
    .remaining  (remaining),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .running    (running),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs();
    check("remaining", int'(remaining), m_rem);
    check("bcd_tens",  int'(bcd_tens),  m_rem / 10);
    check("bcd_ones",  int'(bcd_ones),  m_rem % 10);
    check("running",   int'(running),   (m_state == 1) ? 1 : 0);
    check("timer_en",  int'(timer_en),  (m_state == 1) ? 1 : 0);
    check("expired",   int'(expired),   m_exp);
  endtask

  task automatic model_step(input bit st, input bit pa, input bit ca, input int lv, input bit tk);
    int v;
    m_exp = 0;
    if (ca) begin
      m_state = 0;
      m_rem   = 0;
    end else if (st) begin
      if (m_state == 0 || m_state == 3) begin
        v = (lv > 99) ? 99 : lv;
        m_rem = v;
        if (v == 0) begin
          m_state = 3;
          m_exp   = 1;
        end else begin
          m_state = 1;
        end
      end
    end else if (m_state == 1) begin
      if (tk && m_rem > 0) m_rem = m_rem - 1;
      if (tk && m_rem == 0) begin
        m_state = 3;
        m_exp   = 1;
      end else if (pa) begin
        m_state = 2;
      end
    end else if (m_state == 2 && pa) begin
      m_state = 1;
    end
  endtask

  task automatic cycle(input bit st, input bit pa, input bit ca, input int lv, input bit tk);
    @(negedge clk);
    start      = st;
    pause      = pa;
    cancel     = ca;
    load_value = 7'(lv);
    tick       = tk;
    @(posedge clk);
    model_step(st, pa, ca, lv, tk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic tick_after(input int gap);
    idle(gap);
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_state = 0;
    m_rem   = 0;
    m_exp   = 0;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; pause = 0; cancel = 0; tick = 0; load_value = '0;
    m_state = 0; m_rem = 0; m_exp = 0;
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Reset mid-count, then a clean load afterwards
    cycle(1, 0, 0, 20, 0);
    tick_after(3);
    async_reset();
    cycle(1, 0, 0, 7, 0);
    check("load_after_reset", int'(remaining), 7);
    cycle(0, 0, 1, 0, 0);

    // Basic countdown 3 -> 0 with ticks 10 cycles apart
    cycle(1, 0, 0, 3, 0);
    for (int k = 0; k < 3; k++) tick_after(9);
    idle(3);

    // Clamp and BCD, then zero load
    cycle(1, 0, 0, 120, 0);
    check("clamp", int'(remaining), 99);
    idle(2);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("zero_load_expired", int'(expired), 1);
    idle(2);

    // Pause/resume: 5, tick, pause, 3 ignored ticks, resume, tick
    cycle(1, 0, 0, 5, 0);
    tick_after(4);
    cycle(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick_after(2);
    check("paused_rem", int'(remaining), 4);
    cycle(0, 1, 0, 0, 0);
    check("resume_timer_en", int'(timer_en), 1);
    tick_after(4);
    check("after_resume", int'(remaining), 3);

    // Ignored start while running
    cycle(1, 0, 0, 9, 0);
    idle(1);

    // Down to 1 then pause+tick together -> expired wins
    tick_after(1);
    tick_after(1);
    cycle(0, 1, 0, 0, 1);
    check("pause_tick_expire", int'(expired), 1);
    idle(2);

    // Cancel with tick
    cycle(1, 0, 0, 4, 0);
    cycle(0, 0, 1, 0, 1);
    idle(2);

    // Tick in idle
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);

    // Random requests against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 11) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127)),
            ($urandom_range(0, 3) == 0));
      if (i % 997 == 500) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
